user_project_wrapper: RTL and testbench
=======================================

USER_PROJECT_WRAPPER -- requirements
Module: user_project_wrapper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 106: UART bit time in clocks.
REQ-002 Parameter FLASH_ADDR, default 24'h000000: first flash byte address read.
REQ-003 Parameter MAX_BYTES, default 256: maximum bytes streamed.
REQ-004 io_in[8]  input  1  clock; the only clock, rising edge.
REQ-005 io_in[9]  input  1  reset; asynchronous, active-low (design_rstn).
REQ-006 vdd, vss  inout  1 each  power and ground; no logic function.
REQ-007 io_in  input  38  pads in; bit 13 = flash MISO (io1), bit 17 = ser_rx (unused); other bits ignored.
REQ-008 io_out  output  38  pads out; 10 = flash_csb, 11 = flash_clk, 12 = flash MOSI (io0), 14/15 = WP#/HOLD# (constant 1), 16 = ser_tx, 37:22 = leds[15:0]; other bits 0.
REQ-009 io_oeb  output  38  active-low enables; 0 on bits 10,11,12,14,15,16,22–37; 1 on all other bits.

Function
REQ-010 Flash access SHALL use SPI mode 0, single-bit: SCK idle low, period 4 clocks (2 high, 2 low); MOSI changes on SCK fall, MISO sampled on SCK rise; MSB first.
REQ-011 FSM states SHALL be: IDLE, WAKE_CMD, WAKE_WAIT, READ_CMD, READ_BYTE, UART_TX, DONE.
REQ-012 IDLE: on reset release, wait 16 clocks with csb=1, then go to WAKE_CMD.
REQ-013 WAKE_CMD: assert csb=0, shift command 0xAB (release power-down), then csb=1 and go to WAKE_WAIT.
REQ-014 WAKE_WAIT: hold csb=1 for 400 clocks (≥ tRES), then go to READ_CMD.
REQ-015 READ_CMD: assert csb=0, shift 0x03 then FLASH_ADDR (24 bits MSB first), then go to READ_BYTE; csb stays 0.
REQ-016 READ_BYTE: clock in 8 bits; if byte == 0x00 or count == MAX_BYTES go to DONE, else latch byte and go to UART_TX.
REQ-017 UART_TX: SCK held low (paused); transmit 8N1, LSB first, each bit CLKS_PER_BIT clocks: start 0, 8 data, stop 1; count += 1; return to READ_BYTE.
REQ-018 The zero terminator SHALL NOT be transmitted.
REQ-019 DONE: csb=1, SCK=0, ser_tx=1, state held until reset.
REQ-020 leds[8:0] SHALL show count (0..256, saturating at MAX_BYTES); leds[15] = 1 in DONE only; leds[14:9] = 0.
REQ-021 ser_tx SHALL idle high whenever not in UART_TX.
REQ-022 count reaching MAX_BYTES after a transmit SHALL end the stream at the next READ_BYTE without transmitting.

Reset
REQ-023 Async reset SHALL force: state IDLE, csb=1, SCK=0, MOSI=0, ser_tx=1, count=0, leds=0; io_oeb values per REQ-009 are constant.
REQ-024 Reset asserted mid-transfer SHALL abort immediately (csb=1); the sequence restarts from IDLE on release.

Structure
REQ-025 FSM state encoding, command opcodes (0xAB, 0x03) and timing constants (16, 400, SCK divide 4) SHALL live in a shared package.
REQ-026 One sub-module, uart_tx (byte in, start/busy handshake, tx out), SHALL be instantiated; the SPI shifter and FSM stay in the wrapper.

Verification
REQ-027 Flash holds "Hi\n",0x00 at 0 -> serial 'H','i',10 at 106 clk/bit; leds = 16'h8003; csb high after the terminator.
REQ-028 Flash byte 0 = 0x00 -> no serial traffic; leds = 16'h8000.
REQ-029 Flash filled with 0x41 (no terminator) -> exactly 256 'A' characters; leds = 16'h8100.
REQ-030 Monitor flash pins -> first transaction 0xAB alone, ≥400 clocks csb high, then 0x03,0x00,0x00,0x00; SCK low while csb high.
REQ-031 Reset pulse during the 2nd UART character -> csb=1 and ser_tx=1 within 1 clock; after release the stream restarts with 'H'.
REQ-032 Check io_oeb equals the REQ-009 pattern and unused io_out bits are 0 throughout.

Source files
------------

// File: rtl/user_project_wrapper_pkg.sv
// ============================================================================
// user_project_wrapper_pkg : shared FSM encoding, flash opcodes, timing, pads
// Rev 1.0
// ============================================================================
`default_nettype none

package user_project_wrapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAKE_CMD  = 3'd1,
    ST_WAKE_WAIT = 3'd2,
    ST_READ_CMD  = 3'd3,
    ST_READ_BYTE = 3'd4,
    ST_UART_TX   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [7:0] c_cmd_release_pd = 8'hAB;
  localparam logic [7:0] c_cmd_read       = 8'h03;

  localparam int c_idle_clks      = 16;
  localparam int c_wake_wait_clks = 400;
  localparam int c_sck_div        = 4;

  localparam int c_pad_clk    = 8;
  localparam int c_pad_rstn   = 9;
  localparam int c_pad_csb    = 10;
  localparam int c_pad_sck    = 11;
  localparam int c_pad_mosi   = 12;
  localparam int c_pad_miso   = 13;
  localparam int c_pad_wp     = 14;
  localparam int c_pad_hold   = 15;
  localparam int c_pad_tx     = 16;
  localparam int c_pad_led_lo = 22;

  // Output enables are active low: only the flash, UART and LED pads drive.
  function automatic logic [37:0] pad_oeb();
    logic [37:0] v;
    v = '1;
    v[c_pad_csb]  = 1'b0;
    v[c_pad_sck]  = 1'b0;
    v[c_pad_mosi] = 1'b0;
    v[c_pad_wp]   = 1'b0;
    v[c_pad_hold] = 1'b0;
    v[c_pad_tx]   = 1'b0;
    for (int i = c_pad_led_lo; i < 38; i++) v[i] = 1'b0;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/user_project_wrapper_uart_tx.sv
// ============================================================================
// uart_tx : 8N1 transmitter, LSB first, start/busy handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 106
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [3:0]         r_bit_idx;
  logic [8:0]         r_frame;
  logic               r_busy;
  logic               r_tx;

  // r_frame holds the bits still to send after the current one (data then stop).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_frame   <= '1;
      r_busy    <= 1'b0;
      r_tx      <= 1'b1;
    end else if (!r_busy) begin
      if (i_start) begin
        r_frame   <= {1'b1, i_data};
        r_tx      <= 1'b0;
        r_busy    <= 1'b1;
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
      end
    end else if (r_clk_cnt == c_cnt_w'(CLKS_PER_BIT - 1)) begin
      r_clk_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        r_tx      <= r_frame[0];
        r_frame   <= {1'b1, r_frame[8:1]};
      end
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_tx   = r_tx;

endmodule

`default_nettype wire

// File: rtl/user_project_wrapper.sv
// ============================================================================
// user_project_wrapper : wakes a SPI flash, streams bytes from it to a UART
// Rev 1.0
// ============================================================================
`default_nettype none

module user_project_wrapper
  import user_project_wrapper_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 106,
  parameter logic [23:0] FLASH_ADDR   = 24'h000000,
  parameter int          MAX_BYTES    = 256
) (
  inout  wire         vdd,
  inout  wire         vss,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  logic w_clk;
  logic w_rst_n;
  logic w_miso;
  logic w_tx;
  logic w_uart_busy;
  logic w_unused;

  assign w_clk    = io_in[c_pad_clk];
  assign w_rst_n  = io_in[c_pad_rstn];
  assign w_miso   = io_in[c_pad_miso];
  assign w_unused = &{1'b0, io_in[37:14], io_in[12:10], io_in[7:0], vdd, vss};

  state_t      r_state;
  state_t      w_next_state;
  logic [8:0]  r_wait_cnt;
  logic [1:0]  r_phase;
  logic [5:0]  r_bits_left;
  logic [30:0] r_shift;
  logic [7:0]  r_rx;
  logic [8:0]  r_count;
  logic        r_csb;
  logic        r_sck;
  logic        r_mosi;

  logic        w_spi_active;
  logic        w_spi_rise;
  logic        w_spi_fall;
  logic        w_spi_last;
  logic        w_spi_load;
  logic [31:0] w_spi_data;
  logic [5:0]  w_spi_bits;
  logic        w_csb_lo;
  logic        w_csb_hi;
  logic        w_uart_start;
  logic        w_cnt_inc;

  // Each bit cell is two clocks SCK low then two high; a zero bit count pauses SCK.
  assign w_spi_active = (r_bits_left != '0);
  assign w_spi_rise   = w_spi_active && (r_phase == 2'(c_sck_div / 2 - 1));
  assign w_spi_fall   = w_spi_active && (r_phase == 2'(c_sck_div - 1));
  assign w_spi_last   = w_spi_fall && (r_bits_left == 6'd1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_spi_load   = 1'b0;
    w_spi_data   = '0;
    w_spi_bits   = '0;
    w_csb_lo     = 1'b0;
    w_csb_hi     = 1'b0;
    w_uart_start = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_wait_cnt == 9'(c_idle_clks - 1)) begin
          w_next_state = ST_WAKE_CMD;
          w_spi_load   = 1'b1;
          w_spi_data   = {c_cmd_release_pd, 24'h000000};
          w_spi_bits   = 6'd8;
          w_csb_lo     = 1'b1;
        end
      end
      ST_WAKE_CMD: begin
        if (w_spi_last) begin
          w_next_state = ST_WAKE_WAIT;
          w_csb_hi     = 1'b1;
        end
      end
      ST_WAKE_WAIT: begin
        if (r_wait_cnt == 9'(c_wake_wait_clks - 1)) begin
          w_next_state = ST_READ_CMD;
          w_spi_load   = 1'b1;
          w_spi_data   = {c_cmd_read, FLASH_ADDR};
          w_spi_bits   = 6'd32;
          w_csb_lo     = 1'b1;
        end
      end
      ST_READ_CMD: begin
        if (w_spi_last) begin
          w_next_state = ST_READ_BYTE;
          w_spi_load   = 1'b1;
          w_spi_bits   = 6'd8;
        end
      end
      ST_READ_BYTE: begin
        // r_rx is complete here: the eighth sample was taken on this bit's rise.
        if (w_spi_last) begin
          if ((r_rx == 8'h00) || (r_count == 9'(MAX_BYTES))) begin
            w_next_state = ST_DONE;
            w_csb_hi     = 1'b1;
          end else begin
            w_next_state = ST_UART_TX;
            w_uart_start = 1'b1;
          end
        end
      end
      ST_UART_TX: begin
        if (!w_uart_busy) begin
          w_next_state = ST_READ_BYTE;
          w_spi_load   = 1'b1;
          w_spi_bits   = 6'd8;
          w_cnt_inc    = 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wait_cnt  <= '0;
      r_phase     <= '0;
      r_bits_left <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_count     <= '0;
      r_csb       <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      if (r_state != w_next_state) r_wait_cnt <= '0;
      else if (r_wait_cnt != '1)   r_wait_cnt <= r_wait_cnt + 9'd1;

      if (w_csb_lo)      r_csb <= 1'b0;
      else if (w_csb_hi) r_csb <= 1'b1;

      if (w_spi_load) begin
        r_mosi      <= w_spi_data[31];
        r_shift     <= w_spi_data[30:0];
        r_bits_left <= w_spi_bits;
        r_phase     <= '0;
        r_sck       <= 1'b0;
      end else if (w_spi_active) begin
        r_phase <= w_spi_fall ? 2'd0 : r_phase + 2'd1;
        if (w_spi_rise) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], w_miso};
        end
        if (w_spi_fall) begin
          r_sck       <= 1'b0;
          r_bits_left <= r_bits_left - 6'd1;
          r_mosi      <= r_shift[30];
          r_shift     <= {r_shift[29:0], 1'b0};
        end
      end

      if (w_cnt_inc && (r_count != 9'(MAX_BYTES))) r_count <= r_count + 9'd1;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (w_clk),
    .rst_n   (w_rst_n),
    .i_data  (r_rx),
    .i_start (w_uart_start),
    .o_busy  (w_uart_busy),
    .o_tx    (w_tx)
  );

  always_comb begin
    io_out              = '0;
    io_out[c_pad_csb]   = r_csb;
    io_out[c_pad_sck]   = r_sck;
    io_out[c_pad_mosi]  = r_mosi;
    io_out[c_pad_wp]    = 1'b1;
    io_out[c_pad_hold]  = 1'b1;
    io_out[c_pad_tx]    = w_tx;
    io_out[37:22]       = {(r_state == ST_DONE), 6'b000000, r_count};
  end

  assign io_oeb = pad_oeb();

endmodule

`default_nettype wire

// File: tb/tb_user_project_wrapper.sv
// ============================================================================
// tb_user_project_wrapper : flash model + UART receiver around the wrapper
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_user_project_wrapper;

  localparam int CPB     = 8;
  localparam int MAXB    = 256;
  localparam int MEM_SZ  = 1024;
  localparam int BUDGET  = 60000;

  logic        clk;
  logic        rst_n;
  logic        miso;
  wire  [37:0] io_in;
  wire  [37:0] io_out;
  wire  [37:0] io_oeb;
  wire         vdd;
  wire         vss;

  assign vdd   = 1'b1;
  assign vss   = 1'b0;
  assign io_in = {20'd0, 1'b1, 3'b000, miso, 3'b000, rst_n, clk, 8'd0};

  user_project_wrapper #(
    .CLKS_PER_BIT (CPB),
    .FLASH_ADDR   (24'h000000),
    .MAX_BYTES    (MAXB)
  ) dut (
    .vdd    (vdd),
    .vss    (vss),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  wire        csb  = io_out[10];
  wire        sck  = io_out[11];
  wire        mosi = io_out[12];
  wire        tx   = io_out[16];
  wire [15:0] leds = io_out[37:22];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI flash model (mode 0, READ 0x03) ----------------
  logic [7:0]  flash_mem [0:MEM_SZ-1];
  int          rise_cnt = 0;
  int          fk;
  logic [31:0] sh = '0;
  logic [31:0] hdr = '0;
  int          cyc = 0;
  int          last_csb_rise = 0;
  int          txn_bits[$];
  logic [31:0] txn_first[$];
  int          gaps[$];

  initial miso = 1'b0;
  always @(posedge clk) cyc++;

  always @(posedge sck) begin
    if (!csb) begin
      sh = {sh[30:0], mosi};
      rise_cnt++;
      if (rise_cnt == 32) hdr = sh;
    end
  end

  always @(negedge sck) begin
    if (!csb && rise_cnt >= 32 && hdr[31:24] == 8'h03) begin
      fk   = rise_cnt - 32;
      miso = flash_mem[(int'(hdr[23:0]) + fk / 8) % MEM_SZ][7 - (fk % 8)];
    end
  end

  always @(posedge csb) begin
    if (rise_cnt > 0) begin
      txn_bits.push_back(rise_cnt);
      txn_first.push_back(rise_cnt >= 32 ? hdr : {24'h0, sh[7:0]});
    end
    rise_cnt      = 0;
    sh            = '0;
    hdr           = '0;
    last_csb_rise = cyc;
  end

  always @(negedge csb) gaps.push_back(cyc - last_csb_rise);

  // ---------------- UART receiver ----------------
  logic [7:0] rxq[$];
  int         frame_err = 0;

  initial begin
    logic [7:0] d;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(posedge clk);
      if (tx == 1'b0) begin
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(posedge clk);
          d[b] = tx;
        end
        repeat (CPB) @(posedge clk);
        if (tx != 1'b1) frame_err++;
        rxq.push_back(d);
      end
    end
  end

  // ---------------- Continuous pad checks ----------------
  logic [37:0] exp_oeb;
  int oeb_viol = 0, unused_viol = 0, sck_viol = 0, const_viol = 0;

  initial begin
    exp_oeb = '1;
    foreach (exp_oeb[i]) begin
      if (i == 10 || i == 11 || i == 12 || i == 14 || i == 15 || i == 16 || i >= 22)
        exp_oeb[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (io_oeb != exp_oeb)                  oeb_viol++;
    if ((io_out & exp_oeb) != '0)           unused_viol++;
    if (csb && sck)                         sck_viol++;
    if (!io_out[14] || !io_out[15] || leds[14:9] != 6'd0) const_viol++;
  end

  // ---------------- Reference model ----------------
  logic [7:0] expq[$];

  function automatic void build_expected();
    expq.delete();
    for (int i = 0; i < MAXB; i++) begin
      if (flash_mem[i] == 8'h00) break;
      expq.push_back(flash_mem[i]);
    end
  endfunction

  function automatic logic [15:0] model_leds();
    return {1'b1, 6'd0, 9'(expq.size())};
  endfunction

  // ---------------- Helpers ----------------
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    repeat (hold) @(posedge clk);
    rxq.delete();
    txn_bits.delete();
    txn_first.delete();
    gaps.delete();
    frame_err = 0;
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!leds[15] && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, leds[15], 1);
    repeat (CPB * 2) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input logic [15:0] want_leds, input int want_n);
    int bad;
    build_expected();
    check({tag, "_leds"}, leds, want_leds);
    check({tag, "_char_count"}, rxq.size(), want_n);
    bad = -1;
    for (int i = 0; i < rxq.size() && i < expq.size(); i++)
      if (rxq[i] != expq[i] && bad < 0) bad = i;
    check({tag, "_first_bad_char_idx"}, bad, -1);
    check({tag, "_csb_high"}, csb, 1);
    check({tag, "_tx_idle"}, tx, 1);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic load_kind(input int kind, input int len);
    for (int i = 0; i < MEM_SZ; i++) flash_mem[i] = 8'($urandom_range(0, 255));
    case (kind)
      0: begin
        flash_mem[0] = 8'h48; flash_mem[1] = 8'h69;
        flash_mem[2] = 8'h0A; flash_mem[3] = 8'h00;
      end
      1: flash_mem[0] = 8'h00;
      2: for (int i = 0; i < MEM_SZ; i++) flash_mem[i] = 8'h41;
      default: begin
        for (int i = 0; i < len; i++) flash_mem[i] = 8'h7E;
        flash_mem[len] = 8'h00;
      end
    endcase
  endtask

  typedef struct {
    int          kind;
    int          len;
    logic [15:0] exp_leds;
    int          exp_chars;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int wt;
    int g1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    vecs[0] = '{kind: 0, len: 0, exp_leds: 16'h8003, exp_chars: 3};
    vecs[1] = '{kind: 1, len: 0, exp_leds: 16'h8000, exp_chars: 0};
    vecs[2] = '{kind: 3, len: 5, exp_leds: 16'h8005, exp_chars: 5};
    vecs[3] = '{kind: 2, len: 0, exp_leds: 16'h8100, exp_chars: 256};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_csb", csb, 1);
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    check("reset_tx", tx, 1);
    check("reset_leds", leds, 16'h0000);

    for (int v = 0; v < 4; v++) begin
      load_kind(vecs[v].kind, vecs[v].len);
      do_reset(4);
      wait_done($sformatf("vec%0d", v));
      check_stream($sformatf("vec%0d", v), vecs[v].exp_leds, vecs[v].exp_chars);
      if (v == 0) begin
        check("proto_txn_count", txn_bits.size(), 2);
        check("proto_wake_bits", txn_bits.size() > 0 ? txn_bits[0] : -1, 8);
        check("proto_wake_cmd", txn_first.size() > 0 ? txn_first[0] : 0, 32'h0000_00AB);
        check("proto_read_hdr", txn_first.size() > 1 ? txn_first[1] : 0, 32'h0300_0000);
        g1 = gaps.size() > 1 ? gaps[1] : 0;
        check("proto_wake_gap_ge_400", (g1 >= 400) ? 1 : 0, 1);
      end
    end

    // Reset pulse during the second character
    load_kind(0, 0);
    do_reset(4);
    wt = 0;
    while (rxq.size() < 1 && wt < BUDGET) begin @(negedge clk); wt++; end
    while (tx != 1'b0 && wt < BUDGET) begin @(negedge clk); wt++; end
    check("midrst_second_char_started", (wt < BUDGET) ? 1 : 0, 1);
    repeat (CPB * 3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_csb", csb, 1);
    check("midrst_tx", tx, 1);
    check("midrst_sck", sck, 0);
    do_reset(CPB * 15);
    wait_done("midrst");
    check("midrst_first_char", rxq.size() > 0 ? rxq[0] : 0, 8'h48);
    check_stream("midrst", 16'h8003, 3);

    // Randomized streams against the reference model
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(0, 12);
      for (int i = 0; i < MEM_SZ; i++) flash_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) flash_mem[i] = 8'($urandom_range(1, 255));
      flash_mem[len] = 8'h00;
      do_reset(4);
      wait_done($sformatf("rnd%0d", r));
      build_expected();
      check_stream($sformatf("rnd%0d", r), model_leds(), expq.size());
    end

    check("pad_oeb_pattern", oeb_viol, 0);
    check("pad_unused_zero", unused_viol, 0);
    check("sck_low_while_csb_high", sck_viol, 0);
    check("pad_constants", const_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
